// File: rtl/cei_mochila_pkg.sv
// Shared types and constants for cei_mochila crossbar peripherals.
package cei_mochila_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } sram_resp_state_e;

    localparam logic [31:0] SRAM_ERR_RDATA = 32'hBADA_CCE5;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } obi_resp_t;

endpackage

// File: rtl/cei_mochila_sram_array.sv
// Synchronous single-port byte-enabled word array; kept apart from the
// responder FSM so a macro SRAM can replace it.
module cei_mochila_sram_array
    import cei_mochila_pkg::*;
#(
    parameter int NumWords  = 16384,
    parameter int AddrWidth = 14
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [3:0]           be,
    input  logic [AddrWidth-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] mem [NumWords];

    // Read data stays in rdata until the next enabled read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/cei_mochila_obi_sram_responder.sv
// OBI SRAM responder for the crossbar memory port, one request in flight.
// Define CEI_MOCHILA_SRAM_ERR_EN to flag out-of-window accesses on err_o.
module cei_mochila_obi_sram_responder
    import cei_mochila_pkg::*;
#(
    parameter int          NumWords   = 16384,
    parameter int          WaitCycles = 0,
    parameter logic [31:0] BaseAddr   = 32'hF010_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int          AW       = (NumWords > 1) ? $clog2(NumWords) : 1;
    // 33-bit end address so a window touching 4 GiB cannot wrap.
    localparam logic [32:0] END_ADDR = {1'b0, BaseAddr} + 33'(NumWords) * 33'd4;

    obi_req_t         obi_req;
    obi_resp_t        obi_resp;
    sram_resp_state_e state;
    logic [3:0]       cnt;
    logic             we_q;
    logic             in_range_q;
    logic             in_range;
    logic             gnt;
    logic [AW-1:0]    idx;
    logic [31:0]      arr_rdata;

    assign obi_req = '{req: req_i, addr: addr_i, we: we_i, be: be_i, wdata: wdata_i};

    assign in_range = ({1'b0, obi_req.addr} >= {1'b0, BaseAddr}) &&
                      ({1'b0, obi_req.addr} <  END_ADDR);
    assign idx      = AW'((obi_req.addr - BaseAddr) >> 2);
    assign gnt      = obi_req.req && (state != WAIT);

    cei_mochila_sram_array #(
        .NumWords  (NumWords),
        .AddrWidth (AW)
    ) u_array (
        .clk   (clk_i),
        .en    (gnt && in_range),
        .we    (obi_req.we),
        .be    (obi_req.be),
        .addr  (idx),
        .wdata (obi_req.wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            in_range_q <= 1'b0;
        end else if (gnt) begin
            we_q       <= obi_req.we;
            in_range_q <= in_range;
            if (WaitCycles == 0) begin
                state <= RESP;
            end else begin
                state <= WAIT;
                cnt   <= 4'(WaitCycles - 1);
            end
        end else if (state == WAIT) begin
            if (cnt == '0) state <= RESP;
            else           cnt   <= cnt - 4'd1;
        end else begin
            state <= IDLE;
        end
    end

    assign obi_resp.gnt    = gnt;
    assign obi_resp.rvalid = (state == RESP);
    // The array output register doubles as the response data register.
    assign obi_resp.rdata  = !obi_resp.rvalid ? 32'h0 :
                             we_q             ? 32'h0 :
                             in_range_q       ? arr_rdata : SRAM_ERR_RDATA;
`ifdef CEI_MOCHILA_SRAM_ERR_EN
    assign obi_resp.err    = obi_resp.rvalid && !in_range_q;
`else
    assign obi_resp.err    = 1'b0;
`endif

    assign gnt_o    = obi_resp.gnt;
    assign rvalid_o = obi_resp.rvalid;
    assign rdata_o  = obi_resp.rdata;
    assign err_o    = obi_resp.err;

endmodule

// File: tb/tb_cei_mochila_obi_sram_responder.sv
// Scoreboard bench: instance 0 has WaitCycles=0, instance 1 WaitCycles=3.
module tb_cei_mochila_obi_sram_responder;

`ifdef CEI_MOCHILA_SRAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    logic        rst    [2];
    logic        req    [2];
    logic        we     [2];
    logic [31:0] addr   [2];
    logic [3:0]  be     [2];
    logic [31:0] wdata  [2];
    logic        gnt    [2];
    logic        rvalid [2];
    logic [31:0] rdata  [2];
    logic        err    [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   last_g;
    int   last_w;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cei_mochila_obi_sram_responder #(
            .NumWords   (16384),
            .WaitCycles (g * 3),
            .BaseAddr   (32'hF010_0000)
        ) u_dut (
            .clk_i    (clk),
            .rst_i    (rst[g]),
            .req_i    (req[g]),
            .gnt_o    (gnt[g]),
            .addr_i   (addr[g]),
            .we_i     (we[g]),
            .be_i     (be[g]),
            .wdata_i  (wdata[g]),
            .rvalid_o (rvalid[g]),
            .rdata_o  (rdata[g]),
            .err_o    (err[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit oor(input logic [31:0] a);
        return (a < 32'hF010_0000) || (a >= 32'hF011_0000);
    endfunction

    task automatic mon(input int d);
        exp_t e;
        int   n;
        n = (d == 0) ? q0.size() : q1.size();
        if (rvalid[d]) begin
            if (n == 0) begin
                chk($sformatf("dut%0d rvalid without pending request", d), {31'b0, rvalid[d]}, 32'h0);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("dut%0d rdata", d), rdata[d], e.rdata);
                chk($sformatf("dut%0d err", d), {31'b0, err[d]}, {31'b0, e.err});
                chk($sformatf("dut%0d response cycle", d), 32'(cyc), 32'(e.due));
            end
        end else begin
            chk($sformatf("dut%0d idle rdata", d), rdata[d], 32'h0);
            chk($sformatf("dut%0d idle err", d), {31'b0, err[d]}, 32'h0);
            if (n > 0) begin
                e = (d == 0) ? q0[0] : q1[0];
                if (e.due < cyc) begin
                    chk($sformatf("dut%0d missing rvalid", d), {31'b0, rvalid[d]}, 32'h1);
                    if (d == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input bit expect_resp);
        bit   got = 1'b0;
        exp_t e;
        req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
        last_w = 0;
        last_g = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gnt[d]) begin got = 1'b1; break; end
            last_w++;
        end
        chk($sformatf("dut%0d grant addr %h", d, a), {31'b0, gnt[d]}, 32'h1);
        if (got) begin
            last_g = cyc;
            if (expect_resp) begin
                e = '{rdata: exp_rd, err: ERR_EN && oor(a), due: cyc + d * 3 + 1};
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
        @(posedge clk); #1;
        if (!got) req[d] = 1'b0;
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [3:0] b, input logic [31:0] wd);
        issue(d, 1'b1, a, b, wd, 32'h0, 1'b1);
    endtask

    task automatic rd(input int d, input logic [31:0] a, input logic [31:0] exp_rd);
        issue(d, 1'b0, a, 4'hF, 32'h0, exp_rd, 1'b1);
    endtask

    task automatic idle(input int d, input int n);
        req[d] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0;
            addr[d] = '0; be[d] = '0; wdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d reset rvalid", d), {31'b0, rvalid[d]}, 32'h0);
            chk($sformatf("dut%0d reset rdata", d), rdata[d], 32'h0);
            chk($sformatf("dut%0d reset gnt", d), {31'b0, gnt[d]}, 32'h0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(posedge clk); #1;

        // Full and partial writes with read-back, zero wait
        wr(0, 32'hF010_0010, 4'hF, 32'hDEAD_BEEF);
        chk("dut0 grant in request cycle", 32'(last_w), 32'h0);
        rd(0, 32'hF010_0010, 32'hDEAD_BEEF);
        wr(0, 32'hF010_0010, 4'b0010, 32'h0000_5500);
        rd(0, 32'hF010_0010, 32'hDEAD_55EF);
        wr(0, 32'hF010_0014, 4'hF, 32'h1234_5678);
        wr(0, 32'hF010_0014, 4'h0, 32'hFFFF_FFFF);
        rd(0, 32'hF010_0016, 32'h1234_5678);
        idle(0, 3);

        // 8 back-to-back reads of consecutive words
        for (int i = 0; i < 8; i++) wr(0, 32'hF010_0100 + 32'(4 * i), 4'hF, 32'h1000_0000 + 32'(i));
        g0 = 0;
        for (int i = 0; i < 8; i++) begin
            rd(0, 32'hF010_0100 + 32'(4 * i), 32'h1000_0000 + 32'(i));
            if (i == 0) g0 = last_g;
            else chk($sformatf("dut0 burst grant %0d cycle", i), 32'(last_g), 32'(g0 + i));
        end
        idle(0, 3);

        // Out-of-window accesses
        wr(0, 32'hF010_FFFC, 4'hF, 32'h1122_3344);
        wr(0, 32'hEFFF_FFFC, 4'hF, 32'hCAFE_F00D);
        rd(0, 32'hF010_FFFC, 32'h1122_3344);
        rd(0, 32'hF011_0000, 32'hBADA_CCE5);
        rd(0, 32'hF00F_FFFC, 32'hBADA_CCE5);
        idle(0, 3);

        // Three wait cycles, request held high across two reads
        wr(1, 32'hF010_0020, 4'hF, 32'hA5A5_0001);
        chk("dut1 first grant immediate", 32'(last_w), 32'h0);
        wr(1, 32'hF010_0024, 4'hF, 32'hA5A5_0002);
        rd(1, 32'hF010_0020, 32'hA5A5_0001);
        g0 = last_g;
        rd(1, 32'hF010_0024, 32'hA5A5_0002);
        chk("dut1 cycles without grant", 32'(last_w), 32'h3);
        chk("dut1 second grant in RESP", 32'(last_g - g0), 32'h4);
        idle(1, 6);

        // Reset while waiting discards the request
        issue(1, 1'b0, 32'hF010_0020, 4'hF, 32'h0, 32'h0, 1'b0);
        req[1] = 1'b0;
        #2 rst[1] = 1'b1;
        #1 chk("dut1 rvalid in reset", {31'b0, rvalid[1]}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b0;
        idle(1, 8);
        rd(1, 32'hF010_0020, 32'hA5A5_0001);
        idle(1, 6);
        idle(0, 1);

        chk("dut0 outstanding responses", 32'(q0.size()), 32'h0);
        chk("dut1 outstanding responses", 32'(q1.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
